// File: rtl/pwm_audio_pkg.sv
// Shared defaults for the PWM audio DAC.
//   SAMPLE_WIDTH  : sample width in bits
//   PWM_PERIOD    : PWM frame length in clocks (2**SAMPLE_WIDTH-1)
//   SILENCE_LEVEL : midscale sample value that produces a ~50% duty
package pwm_audio_pkg;
  localparam int SAMPLE_WIDTH = 12;
  localparam int PWM_PERIOD   = 4095;
  localparam logic [SAMPLE_WIDTH-1:0] SILENCE_LEVEL = 12'd2048;
endpackage

// File: rtl/pwm_frame_counter.sv
// Free-running PWM frame counter: 0,1,..,PERIOD-1 then wraps to 0.
//   clk     : clock, rising edge
//   rst_n   : synchronous active-low reset, forces count to 0
//   count_o : current position within the frame
//   last_o  : high in the final cycle of the frame (capture strobe)
module pwm_frame_counter
  import pwm_audio_pkg::*;
#(
  parameter int WIDTH  = SAMPLE_WIDTH,
  parameter int PERIOD = PWM_PERIOD
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [WIDTH-1:0] count_o,
  output logic             last_o
);
  localparam logic [WIDTH-1:0] LAST = WIDTH'(PERIOD - 1);

  logic [WIDTH-1:0] count_q, count_d;

  assign last_o  = (count_q == LAST);
  assign count_d = last_o ? '0 : count_q + WIDTH'(1);
  assign count_o = count_q;

  always_ff @(posedge clk) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end
endmodule

// File: rtl/pwm_audio.sv
// PWM audio DAC. A sample is captured in the last cycle of each frame and
// sets the number of leading high cycles in the following frame.
//   clk    : clock, rising edge
//   rst_n  : synchronous active-low reset (counter, duty and output to 0)
//   sample : unsigned audio sample, may change on any cycle
//   pwm    : PWM bitstream, straight from a flop
module pwm_audio
  import pwm_audio_pkg::*;
#(
  parameter int WIDTH  = SAMPLE_WIDTH,
  parameter int PERIOD = PWM_PERIOD
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sample,
  output logic             pwm
);
  logic [WIDTH-1:0] count;
  logic             last_cycle;
  logic [WIDTH-1:0] duty_q, duty_d;
  logic             pwm_q, pwm_d;

  pwm_frame_counter #(.WIDTH(WIDTH), .PERIOD(PERIOD)) u_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .count_o (count),
    .last_o  (last_cycle)
  );

  assign duty_d = last_cycle ? sample : duty_q;

  // pwm is registered, so compare against the position of the *next* cycle.
  // At the wrap the next position is 0 and the next duty is the sample being
  // captured, so the new value lands on pwm exactly at frame start.
  // Otherwise count <= PERIOD-2, so count+1 cannot overflow WIDTH bits; any
  // duty >= PERIOD keeps pwm high across the whole frame and the boundary.
  always_comb begin
    pwm_d = 1'b0;
    if (last_cycle) pwm_d = (sample != '0);
    else            pwm_d = ((count + WIDTH'(1)) < duty_q);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      duty_q <= '0;
      pwm_q  <= 1'b0;
    end else begin
      duty_q <= duty_d;
      pwm_q  <= pwm_d;
    end
  end

  assign pwm = pwm_q;
endmodule

// File: tb/tb_pwm_audio.sv
// Directed bench for pwm_audio: default 12-bit/4095 instance for the
// functional scenarios, plus an 8-bit/200 instance for a sine sweep.
module tb_pwm_audio;
  import pwm_audio_pkg::*;

  localparam int P  = 4095;
  localparam int P2 = 200;

  logic        clk = 1'b0;
  logic        rst_n, rst2_n;
  logic [11:0] sample;
  logic [7:0]  sample2;
  logic        pwm, pwm2;

  int vec  = 0;
  int miss = 0;

  always #5 clk = ~clk;

  pwm_audio u_dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .sample (sample),
    .pwm    (pwm)
  );

  pwm_audio #(.WIDTH(8), .PERIOD(P2)) u_sine (
    .clk    (clk),
    .rst_n  (rst2_n),
    .sample (sample2),
    .pwm    (pwm2)
  );

  // Called at the negedge of a frame-start cycle; observes one whole frame and
  // returns at the negedge of the next frame start. Reports the number of high
  // cycles and whether the highs form a clean leading run (no X, no gaps).
  // Optionally changes the main sample when the frame position equals chg_at.
  task automatic measure(input bit sel, input int per, input int chg_at,
                         input logic [11:0] chg_val, output int hi, output bit ok);
    bit   seen_low;
    logic p;
    hi = 0; ok = 1'b1; seen_low = 1'b0;
    for (int i = 0; i < per; i++) begin
      if (i == chg_at) sample = chg_val;
      p = sel ? pwm2 : pwm;
      if (p === 1'b1) begin
        hi++;
        if (seen_low) ok = 1'b0;
      end else if (p === 1'b0) seen_low = 1'b1;
      else ok = 1'b0;
      @(posedge clk); @(negedge clk);
    end
  endtask

  task automatic test_reset;
    int hi; bit ok;
    rst_n = 1'b0; sample = SILENCE_LEVEL;
    repeat (10) begin @(posedge clk); @(negedge clk); end
    vec++;
    if (pwm !== 1'b0) begin miss++; $display("FAIL reset_pwm: got %b expected 0", pwm); end
    rst_n = 1'b1;
    measure(0, P, -1, 12'd0, hi, ok);
    vec++;
    if (hi !== 0 || !ok) begin miss++; $display("FAIL first_frame: got %0d highs ok=%0d expected 0", hi, ok); end
    for (int f = 0; f < 2; f++) begin
      measure(0, P, -1, 12'd0, hi, ok);
      vec++;
      if (hi !== 2048 || !ok) begin miss++; $display("FAIL silence_frame%0d: got %0d highs ok=%0d expected 2048", f, hi, ok); end
    end
  endtask

  task automatic test_zero_full;
    int hi; bit ok;
    sample = 12'd0;
    measure(0, P, -1, 12'd0, hi, ok);
    vec++;
    if (hi !== 2048 || !ok) begin miss++; $display("FAIL zero_prev_frame: got %0d expected 2048", hi); end
    sample = 12'd4095;
    measure(0, P, -1, 12'd0, hi, ok);
    vec++;
    if (hi !== 0 || !ok) begin miss++; $display("FAIL zero_frame: got %0d expected 0", hi); end
    for (int f = 0; f < 3; f++) begin
      measure(0, P, -1, 12'd0, hi, ok);
      vec++;
      if (hi !== P) begin miss++; $display("FAIL full_frame%0d: got %0d expected %0d", f, hi, P); end
    end
  endtask

  task automatic test_midframe;
    int hi; bit ok;
    sample = 12'd100;
    measure(0, P, -1, 12'd0, hi, ok);
    vec++;
    if (hi !== P) begin miss++; $display("FAIL full_boundary: got %0d expected %0d", hi, P); end
    measure(0, P, 1000, 12'd3000, hi, ok);
    vec++;
    if (hi !== 100 || !ok) begin miss++; $display("FAIL mid_change_cur: got %0d ok=%0d expected 100", hi, ok); end
    measure(0, P, -1, 12'd0, hi, ok);
    vec++;
    if (hi !== 3000 || !ok) begin miss++; $display("FAIL mid_change_next: got %0d ok=%0d expected 3000", hi, ok); end
  endtask

  task automatic test_edges;
    int hi; bit ok;
    sample = 12'd1;
    measure(0, P, -1, 12'd0, hi, ok);
    sample = 12'd4094;
    measure(0, P, -1, 12'd0, hi, ok);
    vec++;
    if (hi !== 1 || !ok) begin miss++; $display("FAIL duty_one: got %0d ok=%0d expected 1", hi, ok); end
    measure(0, P, -1, 12'd0, hi, ok);
    vec++;
    if (hi !== 4094 || !ok) begin miss++; $display("FAIL duty_4094: got %0d ok=%0d expected 4094 low-last", hi, ok); end
  endtask

  task automatic test_reset_pulse;
    int hi; bit ok;
    sample = 12'd3000;
    repeat (1500) begin @(posedge clk); @(negedge clk); end
    vec++;
    if (pwm !== 1'b1) begin miss++; $display("FAIL pre_pulse: got %b expected 1", pwm); end
    rst_n = 1'b0;
    @(posedge clk); @(negedge clk);
    vec++;
    if (pwm !== 1'b0) begin miss++; $display("FAIL pulse_pwm: got %b expected 0", pwm); end
    rst_n = 1'b1;
    measure(0, P, -1, 12'd0, hi, ok);
    vec++;
    if (hi !== 0 || !ok) begin miss++; $display("FAIL post_pulse_frame: got %0d expected 0", hi); end
    measure(0, P, -1, 12'd0, hi, ok);
    vec++;
    if (hi !== 3000 || !ok) begin miss++; $display("FAIL resume_frame: got %0d ok=%0d expected 3000", hi, ok); end
  endtask

  task automatic test_sine;
    int hi, prev, exp_hi; bit ok;
    rst2_n = 1'b1;
    prev = 0;
    for (int k = 0; k < 42; k++) begin
      sample2 = 8'($rtoi(128.0 + 127.0 * $sin(6.283185307 * k / 41.0)));
      measure(1, P2, -1, 12'd0, hi, ok);
      exp_hi = (prev > P2) ? P2 : prev;
      vec++;
      if (hi !== exp_hi || !ok) begin
        miss++; $display("FAIL sine_frame%0d: got %0d ok=%0d expected %0d", k, hi, ok, exp_hi);
      end
      prev = int'(sample2);
    end
  endtask

  initial begin
    rst_n = 1'b0; rst2_n = 1'b0;
    sample = SILENCE_LEVEL; sample2 = 8'd0;
    @(negedge clk);
    test_reset;
    test_zero_full;
    test_midframe;
    test_edges;
    test_reset_pulse;
    test_sine;
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule

// File: doc/pwm_audio.md
PWM_AUDIO -- requirements
Module: pwm_audio

Interface
REQ-001 The block SHALL take parameter WIDTH, default 12, as the sample width in bits.
REQ-002 The block SHALL take parameter PERIOD, default 4095 (2**WIDTH-1), as the PWM frame length in clocks; legal range 2..2**WIDTH-1.
REQ-003 The block SHALL have port `clk`, input, 1 bit: single clock; all logic on its rising edge.
REQ-004 The block SHALL have port `rst_n`, input, 1 bit: reset that is synchronous and active-low.
REQ-005 The block SHALL have port `sample`, input, WIDTH bits: unsigned audio sample, midscale 2048 = silence; may change on any cycle.
REQ-006 The block SHALL have port `pwm`, output, 1 bit: PWM bitstream, driven directly from a flop with no combinational path.

Function
REQ-007 A frame counter SHALL count 0,1,…,PERIOD-1 and then wrap to 0 in the next cycle, incrementing once per clock.
REQ-008 Capture: when counter == PERIOD-1, `sample` SHALL be latched into the duty register D; the new D applies from the next frame (counter == 0).
- Sample changes at any other cycle SHALL have no effect on the current frame.
REQ-009 Within each frame, `pwm` SHALL be 1 in exactly the first min(D, PERIOD) cycles and 0 in the remaining cycles.
- Frame start = the cycle in which the counter value is 0.
REQ-010 Duty boundaries:
- D = 0 → `pwm` constantly 0.
- D ≥ PERIOD (4095 at default) → `pwm` constantly 1, with no glitch at the frame boundary.
REQ-011 Latency: a `sample` value present at the capture edge SHALL first appear on `pwm` in the cycle in which the counter value is 0, one clock after capture, with no further pipeline delay.
REQ-012 Frame boundary: a high-to-low or low-to-high step SHALL occur only at D cycles into the frame or at frame start; there SHALL be at most two transitions per frame.
REQ-013 Mean `pwm` duty SHALL equal D/PERIOD exactly, so that an external RC low-pass recovers a level linear in `sample`.
REQ-014 Comparisons SHALL be unsigned at WIDTH bits; the counter SHALL be WIDTH bits wide and SHALL never exceed PERIOD-1.

Reset
REQ-015 While `rst_n` == 0 at a rising edge, the following SHALL be set: counter = 0, D = 0, `pwm` = 0.
REQ-016 Reset asserted mid-frame SHALL abort the frame immediately; no partial-frame state SHALL survive.
REQ-017 After release, the first frame SHALL run with D = 0, so `pwm` is low for PERIOD cycles. The first capture SHALL occur at the end of that frame.

Structure
REQ-018 A shared package `pwm_audio_pkg` SHALL hold the defaults SAMPLE_WIDTH=12 and PWM_PERIOD=4095, plus a helper constant for the silence level 2048.
REQ-019 The frame counter with wrap and capture strobe SHALL be one sub-module, `pwm_frame_counter` (outputs: count, last_cycle strobe); the compare and output flop SHALL sit in `pwm_audio`.
REQ-020 There SHALL be no latches, no internal clock gating, and no multicycle paths.

Verification
REQ-021 Reset held 10 cycles, then released with `sample` = 2048: `pwm` is 0 for the first 4095 cycles; each following frame has exactly 2048 high cycles followed by 2047 low cycles.
REQ-022 `sample` = 0, then 4095: `pwm` is constant 0 for whole frames, then constant 1 across at least 3 consecutive frame boundaries.
REQ-023 `sample` changed from 100 to 3000 at counter = 1000: the current frame still has 100 high cycles; the next frame has 3000 high cycles.
REQ-024 `sample` = 1, and separately `sample` = 4094: one high cycle per frame; 4094 high cycles and one low cycle per frame, with the low cycle last.
REQ-025 `rst_n` pulsed low for 1 cycle mid-frame with `sample` = 3000: `pwm` is 0 next cycle and stays 0 for one full frame; 3000-high frames resume after that.
REQ-026 Sweep `sample` as a 12-bit sine for ≥ 40 frames, checking against a reference model: per-frame high count equals the value latched at the previous frame end, and frame period is always 4095.
